// File: rtl/param_bank_sync_if.sv
// Avalon-MM slave bus bundle for the parameter bank: word address, select,
// active-low write strobe, byte lanes, write data and zero-wait read data.
interface param_bank_sync_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                chipselect;
  logic                write_n;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W-1:0]   readdata;

  // A write is accepted on any edge where chipselect && !write_n; there is no
  // wait-request, and readdata follows address combinationally.
  modport master (
    output address, chipselect, write_n, byteenable, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, byteenable, writedata,
    output readdata
  );
endinterface

// File: rtl/param_bank_sync.sv
// Double-buffered raymarcher parameter bank: the host edits shadow registers,
// which copy atomically to the active outputs at a frame boundary or on demand.
module param_bank_sync #(
  parameter int               NUM_CH    = 8,
  parameter int               DATA_W    = 32,
  parameter int               ADDR_W    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  param_bank_sync_if.slave         avs,
  input  logic                     frame_start,
  output logic [NUM_CH*DATA_W-1:0] out_port,
  output logic                     commit_done
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] shadow [NUM_CH];
  logic [DATA_W-1:0] active [NUM_CH];
  logic              pending;
  logic              auto_en;
  logic [DATA_W-1:0] frame_cnt;
  logic [15:0]       commit_cnt;

  logic              wr_en;
  logic              ctrl_wr;
  logic              commit;
  logic [31:0]       status;

  assign wr_en   = avs.chipselect && !avs.write_n;
  assign ctrl_wr = wr_en && (avs.address == ADDR_W'(NUM_CH));
  // pending/auto_en are used from their registered values, so a CTRL write in
  // the same cycle as frame_start only takes effect on the next frame.
  assign commit  = (frame_start && (pending || auto_en)) ||
                   (ctrl_wr && avs.writedata[2]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) shadow[k] <= RESET_VAL;
    end else if (wr_en) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (avs.address == ADDR_W'(k)) begin
          for (int b = 0; b < NB; b++) begin
            if (avs.byteenable[b]) shadow[k][b*8 +: 8] <= avs.writedata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Active copy samples the pre-edge shadow, so a same-cycle shadow write
  // stays pending in shadow for the next commit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CH; k++) active[k] <= RESET_VAL;
    end else if (commit) begin
      for (int k = 0; k < NUM_CH; k++) active[k] <= shadow[k];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending     <= 1'b0;
      auto_en     <= 1'b0;
      frame_cnt   <= '0;
      commit_cnt  <= '0;
      commit_done <= 1'b0;
    end else begin
      // Setting pending wins over the clear caused by a same-cycle commit.
      if (ctrl_wr && avs.writedata[0]) pending <= 1'b1;
      else if (commit)                 pending <= 1'b0;
      if (ctrl_wr) auto_en <= avs.writedata[1];
      if (frame_start) frame_cnt <= frame_cnt + 1'b1;
      if (commit) commit_cnt <= commit_cnt + 16'd1;
      commit_done <= commit;
    end
  end

  assign status = {commit_cnt, 14'd0, auto_en, pending};

  always_comb begin
    avs.readdata = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (avs.address == ADDR_W'(k)) avs.readdata = shadow[k];
    end
    if (avs.address == ADDR_W'(NUM_CH))     avs.readdata = DATA_W'(status);
    if (avs.address == ADDR_W'(NUM_CH + 1)) avs.readdata = frame_cnt;
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_out
    assign out_port[k*DATA_W +: DATA_W] = active[k];
  end
endmodule

// File: tb/tb_param_bank_sync.sv
// Directed bench for param_bank_sync: read and commit expectations are queued
// by the stimulus and checked by an independent negedge monitor.
module tb_param_bank_sync;
  localparam int NUM_CH = 8;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 4;
  localparam int PW     = NUM_CH * DATA_W;
  localparam int CTRL   = NUM_CH;
  localparam int FRAME  = NUM_CH + 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          frame_start = 1'b0;
  logic [PW-1:0] out_port;
  logic          commit_done;

  param_bank_sync_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  param_bank_sync #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .RESET_VAL('0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .avs(bus.slave),
    .frame_start(frame_start), .out_port(out_port), .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [PW-1:0]     exp_commit_q[$];
  logic [PW-1:0]     exp_port_q[$];
  logic              rd_req = 1'b0;
  logic              port_req = 1'b0;

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops whichever expectation matches the output the DUT presents.
  always @(negedge clk) begin
    if (rd_req) begin
      if (exp_q.size() == 0) check("rd_underflow", 1, 0);
      else check($sformatf("readdata@%0d", bus.address), PW'(bus.readdata), PW'(exp_q.pop_front()));
    end
    if (port_req) begin
      if (exp_port_q.size() == 0) check("port_underflow", 1, 0);
      else check("out_port_hold", out_port, exp_port_q.pop_front());
    end
    if (commit_done) begin
      if (exp_commit_q.size() == 0) check("unexpected_commit_done", 1, 0);
      else check("out_port_on_commit", out_port, exp_commit_q.pop_front());
    end
  end

  function automatic logic [PW-1:0] mk_port(input logic [31:0] c0, c1, c2);
    logic [PW-1:0] p;
    p = '0;
    p[0 +: 32]  = c0;
    p[32 +: 32] = c1;
    p[64 +: 32] = c2;
    return p;
  endfunction

  task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be = 4'hF, input logic fs = 1'b0);
    bus.address    = ADDR_W'(a);
    bus.writedata  = d;
    bus.byteenable = be;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    frame_start    = fs;
    @(posedge clk); #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    frame_start    = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic rd(input int a, input logic [31:0] exp);
    bus.address = ADDR_W'(a);
    exp_q.push_back(exp);
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic chk_port(input logic [PW-1:0] exp);
    exp_port_q.push_back(exp);
    port_req = 1'b1;
    @(posedge clk); #1;
    port_req = 1'b0;
  endtask

  initial begin
    bus.address = '0; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus.byteenable = '0; bus.writedata = '0;
    #12 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    for (int a = 0; a < NUM_CH + 2; a++) rd(a, 32'h0);
    chk_port('0);
    check("commit_done_reset", PW'(commit_done), PW'(0));

    // Frame without pending/auto: no commit; then pending commits on frame
    wr(2, 32'h3F80_0000);
    pulse_frame();
    rd(FRAME, 32'd1);
    chk_port('0);
    wr(CTRL, 32'h1);
    rd(CTRL, 32'h0000_0001);
    exp_commit_q.push_back(mk_port(0, 0, 32'h3F80_0000));
    pulse_frame();
    rd(CTRL, 32'h0001_0000);
    rd(FRAME, 32'd2);

    // Byte-lane write, then immediate commit
    wr(0, 32'hAABB_CCDD);
    wr(0, 32'h1122_3344, 4'h3);
    rd(0, 32'hAABB_3344);
    exp_commit_q.push_back(mk_port(32'hAABB_3344, 0, 32'h3F80_0000));
    wr(CTRL, 32'h4);
    rd(CTRL, 32'h0002_0000);
    chk_port(mk_port(32'hAABB_3344, 0, 32'h3F80_0000));

    // auto_en: shadow write concurrent with frame_start commits old value
    wr(CTRL, 32'h2);
    rd(CTRL, 32'h0002_0002);
    exp_commit_q.push_back(mk_port(32'hAABB_3344, 0, 32'h3F80_0000));
    wr(1, 32'd5, 4'hF, 1'b1);
    rd(1, 32'd5);
    exp_commit_q.push_back(mk_port(32'hAABB_3344, 32'd5, 32'h3F80_0000));
    pulse_frame();
    rd(CTRL, 32'h0004_0002);

    // Pending set concurrent with frame_start: commit deferred to next frame
    wr(CTRL, 32'h0);
    wr(CTRL, 32'h1, 4'hF, 1'b1);
    rd(CTRL, 32'h0004_0001);
    exp_commit_q.push_back(mk_port(32'hAABB_3344, 32'd5, 32'h3F80_0000));
    pulse_frame();
    rd(CTRL, 32'h0005_0000);
    rd(FRAME, 32'd6);

    // Immediate commit + pending frame_start: exactly one commit
    wr(CTRL, 32'h1);
    exp_commit_q.push_back(mk_port(32'hAABB_3344, 32'd5, 32'h3F80_0000));
    wr(CTRL, 32'h4, 4'hF, 1'b1);
    rd(CTRL, 32'h0006_0000);
    rd(FRAME, 32'd7);

    // Set + immediate commit in one write: pending stays set
    exp_commit_q.push_back(mk_port(32'hAABB_3344, 32'd5, 32'h3F80_0000));
    wr(CTRL, 32'h5);
    rd(CTRL, 32'h0007_0001);

    // Unmapped address: writes ignored, reads zero
    wr(NUM_CH + 2, 32'hFFFF_FFFF);
    rd(NUM_CH + 2, 32'h0);
    rd(0, 32'hAABB_3344);
    chk_port(mk_port(32'hAABB_3344, 32'd5, 32'h3F80_0000));

    // Asynchronous reset between edges
    bus.address = ADDR_W'(CTRL);
    #2 reset_n = 1'b0;
    #1;
    check("async_out_port", out_port, '0);
    check("async_ctrl", PW'(bus.readdata), PW'(0));
    bus.address = ADDR_W'(FRAME);
    #1;
    check("async_frame", PW'(bus.readdata), PW'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd(0, 32'h0);
    rd(2, 32'h0);
    @(posedge clk); #1;

    check("rd_queue_drained", PW'(exp_q.size()), PW'(0));
    check("commit_queue_drained", PW'(exp_commit_q.size()), PW'(0));
    check("port_queue_drained", PW'(exp_port_q.size()), PW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded limit");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end
endmodule
